serial_frame_deserializer: RTL and testbench

- Consumes the one-bit-per-clock serial stream produced by the shift-register stage and reassembles framed words.
- Frame format: idle-high line, one start bit (0), DATA_WIDTH data bits sent LSB first, an optional parity bit, and one stop bit (1).
- Good words are presented on a valid/ready output port.
- Framing and parity errors are flagged with pulses and counted.

---
 rtl/serial_frame_deserializer.sv | 163 ++++++++++++++++
 tb/tb_serial_frame_deserializer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_deserializer.sv
// ---------------------------------------------------------------------------
// serial_frame_deserializer
//
// Rebuilds words from a one-bit-per-clock serial line. Each frame is a start
// bit (0), DATA_WIDTH data bits LSB first, an optional parity bit and a stop
// bit (1); the line idles high. Good words are offered on a valid/ready port.
// Framing, parity and overrun problems raise one-cycle pulses and bump a
// saturating error counter.
//
// Ports:
//   clk_i        rising-edge system clock
//   reset_ni     asynchronous, active-low reset
//   serial_i     serial line, sampled on every rising edge
//   data_o       received word, stable while valid_o=1 and ready_i=0
//   valid_o      data_o holds a word the consumer has not taken yet
//   ready_i      consumer takes the word on an edge where valid_o=1
//   busy_o       a frame is being received
//   frame_err_o  pulse: stop bit was 0
//   parity_err_o pulse: parity bit did not match the data
//   overrun_o    pulse: good word dropped because the output was still full
//   err_count_o  saturating total of all error pulses
// ---------------------------------------------------------------------------
module serial_frame_deserializer #(
   parameter int DATA_WIDTH    = 8,
   parameter int PARITY_EN     = 0,
   parameter int PARITY_ODD    = 0,
   parameter int ERR_CNT_WIDTH = 8
) (
   input  logic                     clk_i,
   input  logic                     reset_ni,
   input  logic                     serial_i,
   output logic [DATA_WIDTH-1:0]    data_o,
   output logic                     valid_o,
   input  logic                     ready_i,
   output logic                     busy_o,
   output logic                     frame_err_o,
   output logic                     parity_err_o,
   output logic                     overrun_o,
   output logic [ERR_CNT_WIDTH-1:0] err_count_o
);

   localparam int                     CNT_W      = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0]       LAST_BIT   = CNT_W'(DATA_WIDTH - 1);
   localparam logic [CNT_W-1:0]       CNT_ONE    = CNT_W'(1);
   localparam logic [ERR_CNT_WIDTH-1:0] ERR_ONE  = ERR_CNT_WIDTH'(1);
   localparam logic                   ODD_PARITY = (PARITY_ODD != 0);

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } state_e;

   state_e                   state_q;
   logic [CNT_W-1:0]         bitCnt_q;
   logic [DATA_WIDTH-1:0]    shift_q;
   logic [DATA_WIDTH-1:0]    data_q;
   logic                     parityBad_q;
   logic                     valid_q;
   logic                     frameErr_q;
   logic                     parityErr_q;
   logic                     overrun_q;
   logic [ERR_CNT_WIDTH-1:0] errCount_q;

   logic                     parityBad_d;
   logic                     xfer_d;
   logic                     errEvent_d;

   // Decode of the current edge: whether the sampled parity bit disagrees with
   // the collected data, whether the consumer takes the word now, and whether
   // this edge ends a frame with any kind of error. A stop edge is an error if
   // the stop bit is 0, a parity mismatch was remembered, or a good word finds
   // the output still occupied by an untaken word.
   always_comb begin
      parityBad_d = serial_i != ((^shift_q) ^ ODD_PARITY);
      xfer_d      = valid_q & ready_i;
      errEvent_d  = (state_q == STOP) &
                    (~serial_i | parityBad_q | (valid_q & ~ready_i));
   end

   // Frame receiver and output register. Error pulses default low every edge
   // so they last exactly one cycle. The handshake clear is written before the
   // STOP branch so that a word loading on the same edge as a transfer wins
   // and valid stays high. A 0 stop bit sends the machine back to IDLE without
   // treating it as the next start bit.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q     <= IDLE;
         bitCnt_q    <= '0;
         shift_q     <= '0;
         data_q      <= '0;
         parityBad_q <= 1'b0;
         valid_q     <= 1'b0;
         frameErr_q  <= 1'b0;
         parityErr_q <= 1'b0;
         overrun_q   <= 1'b0;
         errCount_q  <= '0;
      end else begin
         frameErr_q  <= 1'b0;
         parityErr_q <= 1'b0;
         overrun_q   <= 1'b0;

         if (xfer_d) begin
            valid_q <= 1'b0;
         end

         if (errEvent_d && (errCount_q != '1)) begin
            errCount_q <= errCount_q + ERR_ONE;
         end

         unique case (state_q)
            IDLE: begin
               if (!serial_i) begin
                  state_q     <= DATA;
                  bitCnt_q    <= '0;
                  parityBad_q <= 1'b0;
               end
            end
            DATA: begin
               shift_q  <= {serial_i, shift_q[DATA_WIDTH-1:1]};
               bitCnt_q <= bitCnt_q + CNT_ONE;
               if (bitCnt_q == LAST_BIT) begin
                  if (PARITY_EN != 0) begin
                     state_q <= PARITY;
                  end else begin
                     state_q <= STOP;
                  end
               end
            end
            PARITY: begin
               parityBad_q <= parityBad_d;
               state_q     <= STOP;
            end
            STOP: begin
               state_q <= IDLE;
               if (!serial_i) begin
                  frameErr_q <= 1'b1;
               end else if (parityBad_q) begin
                  parityErr_q <= 1'b1;
               end else if (valid_q && !ready_i) begin
                  overrun_q <= 1'b1;
               end else begin
                  data_q  <= shift_q;
                  valid_q <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign data_o       = data_q;
   assign valid_o      = valid_q;
   assign busy_o       = (state_q != IDLE);
   assign frame_err_o  = frameErr_q;
   assign parity_err_o = parityErr_q;
   assign overrun_o    = overrun_q;
   assign err_count_o  = errCount_q;

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// ---------------------------------------------------------------------------
// tb_serial_frame_deserializer
//
// Two deserializers share clock and reset: channel 0 uses the default
// configuration (no parity, 8-bit error counter), channel 1 uses even parity
// with a 3-bit error counter so saturation is reached quickly. Frames are
// built from words and error choices; a reference model turns each frame into
// expected words (with the cycle they should appear) and expected error
// events. A monitor watching the DUT outputs pops and compares them.
// ---------------------------------------------------------------------------
module tb_serial_frame_deserializer;

   localparam int K_FRAME   = 1;
   localparam int K_PARITY  = 2;
   localparam int K_OVERRUN = 3;

   logic            clk = 1'b0;
   logic            rstN;
   logic [1:0]      serial;
   logic [1:0]      ready;
   logic [1:0]      validO;
   logic [1:0]      busyO;
   logic [1:0]      frameErr;
   logic [1:0]      parErr;
   logic [1:0]      overrun;
   logic [1:0][7:0] dataO;
   logic [7:0]      errCnt0;
   logic [2:0]      errCnt1;

   int cyc        = 0;
   int compared   = 0;
   int mismatched = 0;
   int readyPct   = 0;

   typedef struct {
      int         ch;
      logic [7:0] data;
      int         cyc;
   } word_t;

   typedef struct {
      int ch;
      int kind;
   } err_t;

   word_t wordQ[$];
   err_t  errQ[$];
   bit    modelValid[2];
   int    expErr[2];
   int    errMax[2] = '{255, 7};
   bit    prevValid[2];
   bit    prevXfer[2];

   serial_frame_deserializer dut0 (
      .clk_i        (clk),
      .reset_ni     (rstN),
      .serial_i     (serial[0]),
      .data_o       (dataO[0]),
      .valid_o      (validO[0]),
      .ready_i      (ready[0]),
      .busy_o       (busyO[0]),
      .frame_err_o  (frameErr[0]),
      .parity_err_o (parErr[0]),
      .overrun_o    (overrun[0]),
      .err_count_o  (errCnt0)
   );

   serial_frame_deserializer #(
      .DATA_WIDTH    (8),
      .PARITY_EN     (1),
      .PARITY_ODD    (0),
      .ERR_CNT_WIDTH (3)
   ) dut1 (
      .clk_i        (clk),
      .reset_ni     (rstN),
      .serial_i     (serial[1]),
      .data_o       (dataO[1]),
      .valid_o      (validO[1]),
      .ready_i      (ready[1]),
      .busy_o       (busyO[1]),
      .frame_err_o  (frameErr[1]),
      .parity_err_o (parErr[1]),
      .overrun_o    (overrun[1]),
      .err_count_o  (errCnt1)
   );

   // Free-running clock and an edge counter used to timestamp expected words.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input int actual, input int expected);
      compared++;
      if (actual != expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic reportFail(input string name, input int actual);
      compared++;
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected nothing (cycle %0d)", name, actual, cyc);
   endtask

   task automatic checkResetState();
      checkOutput("reset ch0 valid", validO[0], 0);
      checkOutput("reset ch0 busy", busyO[0], 0);
      checkOutput("reset ch0 data", dataO[0], 0);
      checkOutput("reset ch0 pulses", {frameErr[0], parErr[0], overrun[0]}, 0);
      checkOutput("reset ch0 errcount", errCnt0, 0);
      checkOutput("reset ch1 valid", validO[1], 0);
      checkOutput("reset ch1 busy", busyO[1], 0);
      checkOutput("reset ch1 data", dataO[1], 0);
      checkOutput("reset ch1 pulses", {frameErr[1], parErr[1], overrun[1]}, 0);
      checkOutput("reset ch1 errcount", errCnt1, 0);
   endtask

   // Reference model for one clock edge. On the stop edge of a frame it
   // decides the frame's fate from the frame-level rules: a 0 stop bit is a
   // framing error, otherwise a bad parity bit is a parity error, otherwise a
   // good word is dropped if the output still holds an untaken word, else it
   // is loaded. On every edge an offered word is taken when ready is high.
   task automatic modelEdge(input int ch, input bit isStop, input logic [7:0] w,
                            input bit stopBit, input bit parBad);
      for (int c = 0; c < 2; c++) begin
         bit loaded;
         loaded = 1'b0;
         if (c == ch && isStop) begin
            if (!stopBit) begin
               errQ.push_back('{c, K_FRAME});
            end else if (parBad) begin
               errQ.push_back('{c, K_PARITY});
            end else if (modelValid[c] && !ready[c]) begin
               errQ.push_back('{c, K_OVERRUN});
            end else begin
               wordQ.push_back('{c, w, cyc + 1});
               loaded = 1'b1;
            end
         end
         if (loaded) begin
            modelValid[c] = 1'b1;
         end else if (modelValid[c] && ready[c]) begin
            modelValid[c] = 1'b0;
         end
      end
   endtask

   // Drive one bit on one channel (the other line idles high), pick ready
   // values for both channels, run the model, and advance one clock.
   task automatic driveBit(input int ch, input bit b, input bit isStop,
                           input logic [7:0] w, input bit parBad);
      serial     = 2'b11;
      serial[ch] = b;
      for (int c = 0; c < 2; c++) begin
         ready[c] = (int'($urandom_range(99)) < readyPct);
      end
      modelEdge(ch, isStop, w, b, parBad);
      @(posedge clk);
      #1;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         driveBit(0, 1'b1, 1'b0, 8'h00, 1'b0);
      end
   endtask

   // Send one complete frame; channel 1 also gets an even-parity bit.
   task automatic applyStimulus(input int ch, input logic [7:0] w,
                                input bit badStop = 1'b0, input bit badPar = 1'b0);
      bit pbit;
      driveBit(ch, 1'b0, 1'b0, w, 1'b0);
      checkOutput("busy after start", busyO[ch], 1);
      for (int i = 0; i < 8; i++) begin
         driveBit(ch, w[i], 1'b0, w, 1'b0);
      end
      if (ch == 1) begin
         pbit = (($countones(w) % 2) == 1) ^ badPar;
         driveBit(ch, pbit, 1'b0, w, 1'b0);
      end
      driveBit(ch, !badStop, 1'b1, w, (ch == 1) && badPar);
      checkOutput("busy after stop", busyO[ch], 0);
   endtask

   task automatic checkDrained();
      checkOutput("words still pending", wordQ.size(), 0);
      checkOutput("errors still pending", errQ.size(), 0);
   endtask

   task automatic pulseReset();
      rstN = 1'b0;
      #1;
      checkResetState();
      for (int c = 0; c < 2; c++) begin
         modelValid[c] = 1'b0;
         expErr[c]     = 0;
         prevValid[c]  = 1'b0;
         prevXfer[c]   = 1'b0;
      end
      wordQ.delete();
      errQ.delete();
      #2;
      rstN = 1'b1;
   endtask

   task automatic popErr(input int c, input int kind, input int errNow);
      if (errQ.size() == 0 || errQ[0].ch != c) begin
         reportFail($sformatf("unexpected error pulse ch%0d kind", c), kind);
      end else begin
         checkOutput($sformatf("error kind ch%0d", c), kind, errQ[0].kind);
         void'(errQ.pop_front());
         if (expErr[c] < errMax[c]) expErr[c]++;
      end
      checkOutput($sformatf("error count ch%0d", c), errNow, expErr[c]);
   endtask

   // Monitor: away from the rising edge, compare whatever the DUTs present
   // against the front of the expectation queues. A newly offered word is
   // checked for value and arrival cycle; a held word must keep its value;
   // a word is retired when ready is high.
   always @(negedge clk) begin
      int errNow;
      if (rstN) begin
         for (int c = 0; c < 2; c++) begin
            errNow = (c == 0) ? int'(errCnt0) : int'(errCnt1);
            if (validO[c]) begin
               if (wordQ.size() == 0 || wordQ[0].ch != c) begin
                  if (!prevValid[c] || prevXfer[c]) begin
                     reportFail($sformatf("unexpected word ch%0d", c), dataO[c]);
                  end
               end else begin
                  checkOutput($sformatf("word data ch%0d", c), dataO[c], wordQ[0].data);
                  if (!prevValid[c] || prevXfer[c]) begin
                     checkOutput($sformatf("word arrival cycle ch%0d", c), cyc, wordQ[0].cyc);
                  end
                  if (ready[c]) void'(wordQ.pop_front());
               end
            end
            if (frameErr[c]) popErr(c, K_FRAME, errNow);
            if (parErr[c])   popErr(c, K_PARITY, errNow);
            if (overrun[c])  popErr(c, K_OVERRUN, errNow);
            prevValid[c] = validO[c];
            prevXfer[c]  = validO[c] && ready[c];
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios first, then randomized frames on each channel, then
   // a run of parity errors to push channel 1's counter into saturation.
   initial begin
      serial = 2'b11;
      ready  = 2'b00;
      rstN   = 1'b1;
      #1;
      rstN = 1'b0;
      #1;
      checkResetState();
      @(posedge clk);
      #1;
      rstN = 1'b1;
      idleCycles(2);

      readyPct = 0;
      applyStimulus(0, 8'hA5);
      idleCycles(3);
      readyPct = 100;
      idleCycles(2);

      applyStimulus(0, 8'h3C);
      applyStimulus(0, 8'hC3);
      idleCycles(2);

      applyStimulus(0, 8'h55, 1'b1);
      applyStimulus(0, 8'h12);
      idleCycles(2);

      readyPct = 0;
      applyStimulus(0, 8'h11);
      applyStimulus(0, 8'h22);
      idleCycles(2);
      readyPct = 100;
      idleCycles(3);
      checkDrained();

      driveBit(0, 1'b0, 1'b0, 8'hF6, 1'b0);
      for (int i = 0; i < 4; i++) begin
         logic [7:0] partial;
         partial = 8'hF6;
         driveBit(0, partial[i], 1'b0, 8'hF6, 1'b0);
      end
      pulseReset();
      idleCycles(5);
      applyStimulus(0, 8'h9A);
      idleCycles(2);

      applyStimulus(1, 8'h07);
      applyStimulus(1, 8'h07, 1'b0, 1'b1);
      idleCycles(2);

      repeat (40) begin
         readyPct = int'($urandom_range(100));
         applyStimulus(0, 8'($urandom), $urandom_range(7) == 0);
         idleCycles(int'($urandom_range(2)));
      end
      readyPct = 100;
      idleCycles(3);
      checkDrained();

      repeat (40) begin
         readyPct = int'($urandom_range(100));
         applyStimulus(1, 8'($urandom), $urandom_range(5) == 0, $urandom_range(3) == 0);
         idleCycles(int'($urandom_range(2)));
      end
      readyPct = 100;
      repeat (9) applyStimulus(1, 8'($urandom), 1'b0, 1'b1);
      idleCycles(3);
      checkDrained();

      checkOutput("final errcount ch0", errCnt0, expErr[0]);
      checkOutput("ch1 errcount saturated", errCnt1, 7);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
